// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register bank with a post-reset clear engine; REGFILE_WRITE_BYPASS_EN selects write-first collisions.
// Latency: reads return one cycle after read_en; writes commit at the edge; ready rises DEPTH cycles after reset.
// Backpressure: none; every read_en accepted while ready is answered, and requests are ignored while clearing.
module regfile_param #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_index_1,
  input  logic [ADDR_W-1:0] read_index_2,
  input  logic              write_enabled,
  input  logic [ADDR_W-1:0] write_index,
  input  logic [DATA_W-1:0] write_value,
  output logic [DATA_W-1:0] read1_value,
  output logic [DATA_W-1:0] read2_value,
  output logic              read_valid,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clear_ptr;
  logic [DATA_W-1:0] bank [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd1_dat, rd2_dat;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clear_ptr == {ADDR_W{1'b1}}) state_nxt = READY;
  end

  always_comb begin
    ready = (state == READY);
  end

  always_ff @(posedge clk) begin
    if (reset)               clear_ptr <= '0;
    else if (state == CLEAR) clear_ptr <= clear_ptr + ADDR_W'(1);
  end

  // Entry 0 is never written when it is hardwired, so it cannot leak through the bypass either.
  always_comb begin
    wr_ok = ready && write_enabled && !(HARDWIRE_ZERO != 0 && write_index == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) bank[clear_ptr] <= '0;
      else if (wr_ok)     bank[write_index] <= write_value;
    end
  end

  always_comb begin
    rd1_dat = bank[read_index_1];
    rd2_dat = bank[read_index_2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_ok && write_index == read_index_1) rd1_dat = write_value;
    if (wr_ok && write_index == read_index_2) rd2_dat = write_value;
`endif
    if (HARDWIRE_ZERO != 0 && read_index_1 == '0) rd1_dat = '0;
    if (HARDWIRE_ZERO != 0 && read_index_2 == '0) rd2_dat = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read1_value <= '0;
      read2_value <= '0;
      read_valid  <= 1'b0;
    end else if (ready && read_en) begin
      read1_value <= rd1_dat;
      read2_value <= rd2_dat;
      read_valid  <= 1'b1;
    end else begin
      read_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the core's integer register bank.
- Generalised data width and depth, optional hardwired-zero entry, and a read handshake with a valid strobe.
- Adds a sequential clear engine that zeroes every entry after reset, so no simulation-only initialisation is needed.
- Sits between decode (read indices) and writeback (write port) in the processor pipeline.

Parameters:
- DATA_W, 32, width of each register entry in bits.
- ADDR_W, 5, index width; depth DEPTH = 2**ADDR_W.
- HARDWIRE_ZERO, 1, when 1 entry 0 is read-only and always reads as 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read_en  input  1  read request; indices sampled this cycle.
- read_index_1  input  ADDR_W  first read index.
- read_index_2  input  ADDR_W  second read index.
- write_enabled  input  1  write request.
- write_index  input  ADDR_W  write index.
- write_value  input  DATA_W  write data.
- read1_value  output  DATA_W  registered data for read_index_1.
- read2_value  output  DATA_W  registered data for read_index_2.
- read_valid  output  1  high for one cycle when read1_value/read2_value hold a fresh result.
- ready  output  1  high when the clear sequence is done and requests are accepted.

Behaviour:
- Interface fixed: single clock clk; reset is synchronous and active-high.
- Reset values: read1_value=0, read2_value=0, read_valid=0, ready=0. The state machine enters CLEAR with clear_ptr=0.
- State CLEAR:
  - Each cycle writes 0 to bank[clear_ptr], then clear_ptr increments.
  - At clear_ptr = DEPTH-1 the write occurs and the state moves to READY on the next edge, so ready rises exactly DEPTH cycles after reset deasserts.
  - read_en and write_enabled are ignored. read_valid stays 0 and the value outputs hold 0.
- Reset asserted mid-CLEAR or mid-READY: the sequence restarts at clear_ptr=0 and outputs return to reset values in the same cycle.
- State READY:
  - Writes:
    - write_enabled=1 commits write_value into bank[write_index] at the edge.
    - With HARDWIRE_ZERO=1, writes to index 0 are dropped.
  - Reads:
    - read_en=1 at edge N produces read1_value, read2_value and read_valid=1 after edge N, i.e. 1-cycle latency.
    - read_en=0: read_valid=0 and the value outputs hold their previous contents.
  - With HARDWIRE_ZERO=1, reading index 0 always returns 0.
  - Both read ports may address the same index; each returns the identical value.
  - Same-cycle read and write to the same nonzero index: see Optional Feature.
- READY is terminal until reset. There are no other states.
- No back-pressure: every read_en in READY is answered. Read data is overwritten on the next accepted read.
- Width rules: indices are used unsigned, full range 0..DEPTH-1 valid, no out-of-range case. Data is stored unmodified.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read that collides with a same-cycle write to the same index returns write_value (write-first forwarding). Applies independently to each read port. A write to index 0 with HARDWIRE_ZERO=1 is not forwarded; 0 is returned.
- Undefined: a colliding read returns the pre-write bank contents (read-first). The new value is visible to reads issued from the next cycle onward.

Test Plan:
- Reset then idle: ready=0 for exactly 32 cycles after reset falls (defaults), ready=1 on cycle 33. Reading all 32 indices pairwise returns 0 with read_valid pulsing once per read_en.
- In READY: write index 5 = 0xDEADBEEF, next cycle read_en with read_index_1=5 and read_index_2=5 -> one cycle later read1_value=read2_value=0xDEADBEEF, read_valid=1.
- HARDWIRE_ZERO=1: write index 0 = 0xFFFFFFFF, then read index 0 -> 0x00000000.
- Same cycle: write index 7 = 0x12345678 (old value 0xA5A5A5A5) and read index 7 -> with REGFILE_WRITE_BYPASS_EN, 0x12345678; without it, 0xA5A5A5A5, then 0x12345678 on a read the following cycle.
- Write index 3 = 0x11, then assert reset for 1 cycle at clear cycle 10 of a second clear sequence -> ready stays low for 32 cycles after that reset, and index 3 then reads 0.
- Writes and read_en during CLEAR: write index 9 = 0x55 at clear cycle 2 -> ignored; after ready, index 9 reads 0 and no read_valid was produced during CLEAR.
